// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } buf_entry_t;

endpackage

// File: rtl/if_buf.sv
// Small FIFO holding fetched {instr, pc} pairs for decode; clear beats push.
module if_buf
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push_i,
    input  buf_entry_t       entry_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output buf_entry_t       head_o
);

    buf_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: storage is reset too, so the head outputs read zero out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: req/ack handshake with instruction memory, PC enable strobe,
// and a small buffer of fetched instructions feeding decode.
module if_fetch
    import if_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_en_o,
    input  logic               flush_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               if_valid_o,
    input  logic               if_ready_i,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [ADDR_W-1:0]  if_pc4_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              push;
    logic              pop;
    logic              issue_ok;
    logic [CNT_W-1:0]  buf_count;
    logic              buf_valid;
    buf_entry_t        buf_head;

    assign pop = buf_valid && if_ready_i;
    // Room for one more entry once this cycle's pop retires; keeps one fetch in flight.
    assign issue_ok = (buf_count - CNT_W'(pop)) <= CNT_W'(BUF_DEPTH - 1);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        pc_en_o  = flush_i || ((state_q == FETCH) && imem_ack_i);
        case (state_q)
            IDLE, STALL: begin
                if (!flush_i && issue_ok) begin
                    state_d  = FETCH;
                    req_pc_d = pc_i;
                end else begin
                    state_d  = STALL;
                end
            end
            FETCH: begin
                if (imem_ack_i) begin
                    state_d = STALL;
                    push    = !flush_i;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack_i) state_d = STALL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    if_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (push),
        .entry_i ('{instr: imem_rdata_i, pc: req_pc_q}),
        .pop_i   (pop),
        .clear_i (flush_i),
        .count_o (buf_count),
        .valid_o (buf_valid),
        .head_o  (buf_head)
    );

    assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o = req_pc_q;
    assign if_valid_o  = buf_valid;
    assign if_instr_o  = buf_head.instr;
    assign if_pc_o     = buf_head.pc;
    assign if_pc4_o    = buf_head.pc + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed phases plus randomized traffic, checked every
// cycle against a transaction-level model of the fetch rules.
module tb_if_fetch;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;

    if_fetch #(.BUF_DEPTH(2)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .pc_i         (pc_i),
        .pc_en_o      (pc_en_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_instr_o   (if_instr_o),
        .if_pc_o      (if_pc_o),
        .if_pc4_o     (if_pc4_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Reference model: pending entries, one outstanding request, the PC register.
    ent_t        q[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    int          m_wait;
    int          m_lat;

    int unsigned ready_pct, flush_pct, stray_pct, lat_min, lat_max;
    int          flush_on_wait;
    int          flush_need_occ;
    bit          tgt_fixed;
    logic [31:0] flush_tgt;
    bit          force_stray;
    bit          rel_pending;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    imem_req_o,  32'd0);
        check({tag, "_addr"},   imem_addr_o, 32'd0);
        check({tag, "_pc_en"},  pc_en_o,     32'd0);
        check({tag, "_valid"},  if_valid_o,  32'd0);
        check({tag, "_instr"},  if_instr_o,  32'd0);
        check({tag, "_pc"},     if_pc_o,     32'd0);
        check({tag, "_pc4"},    if_pc4_o,    32'd4);
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_wait = 0;
        m_lat  = 1;
    endtask

    task automatic cycle();
        bit   ack, flush, ready, pop, exp_valid, exp_pc_en, was_busy;
        logic [31:0] rdata;
        ent_t e;
        @(negedge CLK);
        if (rel_pending) begin
            RST_N       = 1'b1;
            rel_pending = 1'b0;
        end
        rdata = $urandom;
        if (m_busy) ack = (m_wait == m_lat);
        else        ack = force_stray || ($urandom_range(0, 99) < stray_pct);
        force_stray = 1'b0;
        ready = ($urandom_range(0, 99) < ready_pct);
        if (flush_on_wait >= 0) begin
            flush = m_busy && !m_drop && (m_wait == flush_on_wait) &&
                    (flush_need_occ < 0 || q.size() == flush_need_occ);
            if (flush) flush_on_wait = -1;
        end else begin
            flush = ($urandom_range(0, 99) < flush_pct);
        end
        pc_i         = m_pc;
        imem_ack_i   = ack;
        imem_rdata_i = rdata;
        if_ready_i   = ready;
        flush_i      = flush;
        #1;
        exp_valid = (q.size() > 0);
        exp_pc_en = flush || (m_busy && !m_drop && ack);
        check("req", imem_req_o, m_busy);
        if (m_busy) check("addr", imem_addr_o, m_addr);
        check("pc_en", pc_en_o, exp_pc_en);
        check("valid", if_valid_o, exp_valid);
        if (exp_valid) begin
            check("instr", if_instr_o, q[0].instr);
            check("pc",    if_pc_o,    q[0].pc);
            check("pc4",   if_pc4_o,   q[0].pc + 32'd4);
        end
        if (ack && imem_req_o) check("ack_while_full", dut.buf_count == 2'd2, 32'd0);

        was_busy = m_busy;
        pop = exp_valid && ready;
        if (flush) begin
            q.delete();
            if (m_busy && ack) m_busy = 1'b0;
            else if (m_busy)   m_drop = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_busy && ack) begin
                if (!m_drop) begin
                    e.instr = rdata;
                    e.pc    = m_addr;
                    q.push_back(e);
                end
                m_busy = 1'b0;
            end else if (!m_busy && q.size() <= 1) begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = m_pc;
                m_wait = 0;
                m_lat  = int'($urandom_range(lat_min, lat_max));
            end
        end
        if (was_busy && m_busy) m_wait++;
        if (exp_pc_en) begin
            if (flush) m_pc = tgt_fixed ? flush_tgt : ($urandom & 32'hFFFF_FFFC);
            else       m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_knobs(input int unsigned rdy, input int unsigned fl,
                             input int unsigned lmin, input int unsigned lmax,
                             input int unsigned stray);
        ready_pct      = rdy;
        flush_pct      = fl;
        lat_min        = lmin;
        lat_max        = lmax;
        stray_pct      = stray;
        flush_on_wait  = -1;
        flush_need_occ = -1;
        tgt_fixed      = 1'b0;
    endtask

    initial begin
        int budget;
        n_vec = 0;
        n_err = 0;
        force_stray = 1'b0;
        rel_pending = 1'b0;
        set_knobs(100, 0, 1, 1, 0);
        model_reset();
        m_pc         = 32'h3000;
        RST_N        = 1'b0;
        pc_i         = m_pc;
        flush_i      = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        if_ready_i   = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_reset_outputs("reset_hold");
        rel_pending = 1'b1;

        // Single-cycle-late memory, decode always ready.
        run(8);

        // Decode stalled: buffer fills to two, then drains and fetching resumes.
        set_knobs(0, 0, 1, 1, 0);
        run(10);
        set_knobs(100, 0, 1, 1, 0);
        run(6);

        // Slow memory: request held for the whole wait.
        set_knobs(100, 0, 5, 5, 0);
        run(14);

        // Flush two cycles into a slow fetch, redirect to 0x3100.
        set_knobs(100, 0, 5, 5, 0);
        flush_on_wait = 2;
        tgt_fixed     = 1'b1;
        flush_tgt     = 32'h3100;
        run(16);

        // Flush coinciding with ack while one entry is buffered.
        set_knobs(0, 0, 1, 1, 0);
        flush_on_wait  = 1;
        flush_need_occ = 1;
        run(12);
        set_knobs(100, 0, 1, 1, 0);
        run(4);

        // Reset in the middle of a slow fetch, with a stray ack afterwards.
        set_knobs(100, 0, 5, 5, 0);
        budget = 0;
        while (!(m_busy && m_wait == 2) && budget < 30) begin
            cycle();
            budget++;
        end
        check("reset_wait_budget", (m_busy && m_wait == 2), 32'd1);
        @(negedge CLK);
        imem_ack_i = 1'b0;
        flush_i    = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        imem_ack_i = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_outputs("midreset_ack");
        rel_pending = 1'b1;
        force_stray = 1'b1;
        run(10);

        // Randomized traffic with periodically reshuffled knobs.
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(0, 100), $urandom_range(0, 15),
                      1, $urandom_range(1, 6), $urandom_range(0, 30));
            run(200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
